// File: rtl/fp_mul_int_pipe.sv
// Multi-lane pipelined FP x INT multiplier with elastic valid/ready stages and sticky {NV, OF} status.
// Format codes: 0 FP32, 1 FP64, 2 FP16, 3 FP8 (E5M2), 4 FP16ALT (bfloat16).
module fp_mul_int_pipe #(
    parameter int FpFormat_a   = 2,
    parameter int IntWidth     = 4,
    parameter int FpFormat_out = 0,
    parameter int NumLanes     = 4,
    parameter int NumPipeRegs  = 2,
    localparam int EXP_A   = (FpFormat_a == 1) ? 11 : (FpFormat_a == 2 || FpFormat_a == 3) ? 5 : 8,
    localparam int MAN_A   = (FpFormat_a == 0) ? 23 : (FpFormat_a == 1) ? 52 :
                             (FpFormat_a == 2) ? 10 : (FpFormat_a == 3) ? 2 : 7,
    localparam int EXP_O   = (FpFormat_out == 1) ? 11 : (FpFormat_out == 2 || FpFormat_out == 3) ? 5 : 8,
    localparam int MAN_O   = (FpFormat_out == 0) ? 23 : (FpFormat_out == 1) ? 52 :
                             (FpFormat_out == 2) ? 10 : (FpFormat_out == 3) ? 2 : 7,
    localparam int WIDTH_A = 1 + EXP_A + MAN_A,
    localparam int WIDTH_O = 1 + EXP_O + MAN_O
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic                          int_signed_i,
    input  logic [NumLanes-1:0]           lane_en_i,
    input  logic [NumLanes*WIDTH_A-1:0]   operand_a_i,
    input  logic [NumLanes*IntWidth-1:0]  operand_b_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NumLanes*WIDTH_O-1:0]   result_o,
    output logic [NumLanes*2-1:0]         flags_o,
    output logic [1:0]                    status_o,
    input  logic                          clear_status_i
);

    localparam int PW      = MAN_A + 1 + IntWidth;
    localparam int EW      = 16;
    localparam int WW      = PW + MAN_O + 2;
    localparam int BIAS_A  = (1 << (EXP_A - 1)) - 1;
    localparam int BIAS_O  = (1 << (EXP_O - 1)) - 1;
    localparam int EXP_MAX = (1 << EXP_O) - 1;
    localparam int LAST    = NumPipeRegs - 1;

    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    if (IntWidth < 2 || IntWidth > 16) begin : g_bad_int_width
        $error("IntWidth must be within 2..16");
    end
    if (IntWidth > MAN_A + 1) begin : g_bad_int_exact
        $error("IntWidth must not exceed the significand width of operand a");
    end
    if (NumPipeRegs < 1 || NumPipeRegs > 4) begin : g_bad_pipe
        $error("NumPipeRegs must be within 1..4");
    end

    // e is the biased output exponent of the product LSB; prod is the exact integer significand product
    typedef struct packed {
        logic          sign;
        logic [1:0]    cls;
        logic          inv;
        logic [EW-1:0] e;
        logic [PW-1:0] prod;
    } mid_t;

    function automatic mid_t pre_lane(input logic [WIDTH_A-1:0] a, input logic [IntWidth-1:0] b,
                                      input logic sgn);
        mid_t              m;
        logic              sa, sb, a_zero, a_inf, a_nan, b_zero;
        logic [EXP_A-1:0]  ea;
        logic [MAN_A-1:0]  fa;
        logic [MAN_A:0]    siga;
        logic [IntWidth-1:0] bmag;
        int                e_i;
        sa     = a[WIDTH_A-1];
        ea     = a[MAN_A +: EXP_A];
        fa     = a[MAN_A-1:0];
        sb     = sgn & b[IntWidth-1];
        bmag   = sb ? (~b + IntWidth'(1)) : b;
        a_zero = (ea == '0) && (fa == '0);
        a_inf  = (ea == '1) && (fa == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_zero = (b == '0);
        siga   = {(ea != '0), fa};
        e_i    = ((ea == '0) ? 1 : int'(ea)) - BIAS_A - MAN_A + BIAS_O;
        m.sign = sa ^ sb;
        m.inv  = (a_nan & ~fa[MAN_A-1]) | (a_inf & b_zero);
        m.e    = EW'(e_i);
        m.prod = PW'(siga) * PW'(bmag);
        if (a_nan || (a_inf && b_zero)) m.cls = CLS_NAN;
        else if (a_inf)                 m.cls = CLS_INF;
        else if (a_zero || b_zero)      m.cls = CLS_ZERO;
        else                            m.cls = CLS_NUM;
        return m;
    endfunction

    // Returns {invalid, overflow, result}; subnormal results fall out of the right shift by 1-E
    function automatic logic [WIDTH_O+1:0] post_lane(input mid_t m);
        logic [PW-1:0]      sig;
        logic [WW-1:0]      wide, wsh, mask;
        logic [MAN_O:0]     kept;
        logic [MAN_O+1:0]   kr;
        logic [MAN_O-1:0]   mant;
        logic [WIDTH_O-1:0] res;
        logic               rnd, stk, up, ovf;
        int                 msb, ex, sh, eo;
        msb = 0;
        for (int i = 0; i < PW; i++) begin
            if (m.prod[i]) msb = i;
        end
        sig  = m.prod << (PW - 1 - msb);
        ex   = int'(signed'(m.e)) + msb;
        sh   = (ex >= 1) ? 0 : 1 - ex;
        if (sh > WW) sh = WW;
        wide = {sig, {(MAN_O+2){1'b0}}};
        wsh  = wide >> sh;
        mask = ~({WW{1'b1}} << sh);
        kept = wsh[WW-1 -: MAN_O+1];
        rnd  = wsh[PW];
        stk  = (|wsh[PW-1:0]) | (|(wide & mask));
        up   = rnd & (stk | kept[0]);
        kr   = {1'b0, kept} + {{(MAN_O+1){1'b0}}, up};
        if (ex >= 1) begin
            eo   = ex + int'(kr[MAN_O+1]);
            mant = kr[MAN_O+1] ? kr[MAN_O:1] : kr[MAN_O-1:0];
        end else begin
            eo   = int'(kr[MAN_O]);
            mant = kr[MAN_O-1:0];
        end
        ovf = 1'b0;
        case (m.cls)
            CLS_NAN:  res = {1'b0, {EXP_O{1'b1}}, 1'b1, {(MAN_O-1){1'b0}}};
            CLS_INF:  res = {m.sign, {EXP_O{1'b1}}, {MAN_O{1'b0}}};
            CLS_ZERO: res = {m.sign, {(EXP_O+MAN_O){1'b0}}};
            default: begin
                if (eo >= EXP_MAX) begin
                    ovf = 1'b1;
                    res = {m.sign, {EXP_O{1'b1}}, {MAN_O{1'b0}}};
                end else begin
                    res = {m.sign, EXP_O'(eo), mant};
                end
            end
        endcase
        return {m.inv, ovf, res};
    endfunction

    logic [NumPipeRegs-1:0] v_q, v_d, v_in, ld;

    always_comb begin
        logic full;
        full = 1'b1;
        ld   = '0;
        v_in = '0;
        for (int k = NumPipeRegs - 1; k >= 0; k--) begin
            full  = full & v_q[k];
            ld[k] = ~full | out_ready_i;
        end
        v_in[0] = in_valid_i;
        for (int k = 1; k < NumPipeRegs; k++) begin
            v_in[k] = v_q[k-1];
        end
        v_d = v_q;
        for (int k = 0; k < NumPipeRegs; k++) begin
            if (ld[k]) v_d[k] = v_in[k];
        end
    end

    assign in_ready_o  = ~v_q[0] | ld[0];
    assign out_valid_o = v_q[LAST];

    mid_t                mid_in  [NumLanes];
    mid_t                mid_src [NumLanes];
    logic [NumLanes-1:0] en_src;

    always_comb begin
        for (int l = 0; l < NumLanes; l++) begin
            mid_in[l] = pre_lane(operand_a_i[l*WIDTH_A +: WIDTH_A], operand_b_i[l*IntWidth +: IntWidth],
                                 int_signed_i);
        end
    end

    if (NumPipeRegs == 1) begin : g_direct
        always_comb begin
            en_src = lane_en_i;
            for (int l = 0; l < NumLanes; l++) begin
                mid_src[l] = mid_in[l];
            end
        end
    end else begin : g_retime
        localparam int NR = NumPipeRegs - 1;
        mid_t                mid_q [NR][NumLanes];
        mid_t                mid_d [NR][NumLanes];
        logic [NumLanes-1:0] en_q  [NR];
        logic [NumLanes-1:0] en_d  [NR];

        // disabled lanes keep their previous datapath contents
        always_comb begin
            for (int l = 0; l < NumLanes; l++) begin
                mid_d[0][l] = (ld[0] & in_valid_i & lane_en_i[l]) ? mid_in[l] : mid_q[0][l];
            end
            en_d[0] = (ld[0] & in_valid_i) ? lane_en_i : en_q[0];
            for (int k = 1; k < NR; k++) begin
                for (int l = 0; l < NumLanes; l++) begin
                    mid_d[k][l] = (ld[k] & v_q[k-1] & en_q[k-1][l]) ? mid_q[k-1][l] : mid_q[k][l];
                end
                en_d[k] = (ld[k] & v_q[k-1]) ? en_q[k-1] : en_q[k];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int k = 0; k < NR; k++) begin
                    en_q[k] <= '0;
                    for (int l = 0; l < NumLanes; l++) begin
                        mid_q[k][l] <= '0;
                    end
                end
            end else begin
                for (int k = 0; k < NR; k++) begin
                    en_q[k] <= en_d[k];
                    for (int l = 0; l < NumLanes; l++) begin
                        mid_q[k][l] <= mid_d[k][l];
                    end
                end
            end
        end

        always_comb begin
            en_src = en_q[NR-1];
            for (int l = 0; l < NumLanes; l++) begin
                mid_src[l] = mid_q[NR-1][l];
            end
        end
    end

    logic [NumLanes*WIDTH_O-1:0] res_q, res_d;
    logic [NumLanes*2-1:0]       flg_q, flg_d;
    logic [WIDTH_O+1:0]          post [NumLanes];
    logic [1:0]                  status_q, status_d;
    logic                        nv_any, of_any;

    always_comb begin
        res_d = res_q;
        flg_d = flg_q;
        for (int l = 0; l < NumLanes; l++) begin
            post[l] = post_lane(mid_src[l]);
            if (ld[LAST] & v_in[LAST]) begin
                res_d[l*WIDTH_O +: WIDTH_O] = en_src[l] ? post[l][WIDTH_O-1:0] : '0;
                flg_d[l*2 +: 2]             = en_src[l] ? post[l][WIDTH_O +: 2] : 2'b00;
            end
        end
    end

    always_comb begin
        nv_any = 1'b0;
        of_any = 1'b0;
        for (int l = 0; l < NumLanes; l++) begin
            nv_any = nv_any | flg_q[2*l+1];
            of_any = of_any | flg_q[2*l];
        end
        status_d = status_q;
        if (clear_status_i)                  status_d = 2'b00;
        else if (out_valid_o && out_ready_i) status_d = status_q | {nv_any, of_any};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q      <= '0;
            res_q    <= '0;
            flg_q    <= '0;
            status_q <= 2'b00;
        end else begin
            v_q      <= v_d;
            res_q    <= res_d;
            flg_q    <= flg_d;
            status_q <= status_d;
        end
    end

    assign result_o = res_q;
    assign flags_o  = flg_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_fp_mul_int_pipe.sv
// Directed bench for fp_mul_int_pipe with default parameters (4 lanes, FP16 x INT4 -> FP32, 2 stages).
module tb_fp_mul_int_pipe;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic         int_signed_i;
    logic [3:0]   lane_en_i;
    logic [63:0]  operand_a_i;
    logic [15:0]  operand_b_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] result_o;
    logic [7:0]   flags_o;
    logic [1:0]   status_o;
    logic         clear_status_i;

    fp_mul_int_pipe dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .int_signed_i   (int_signed_i),
        .lane_en_i      (lane_en_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .flags_o        (flags_o),
        .status_o       (status_o),
        .clear_status_i (clear_status_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    localparam logic [63:0]  A1 = {16'h8000, 16'hFC00, 16'h7BFF, 16'h3E00};
    localparam logic [15:0]  B1 = {4'h5, 4'h3, 4'h8, 4'hD};
    localparam logic [127:0] E1 = {32'h80000000, 32'hFF800000, 32'hC8FFE000, 32'hC0900000};
    localparam logic [63:0]  A2 = {16'h3C00, 16'h7C00, 16'h0001, 16'h3E00};
    localparam logic [15:0]  B2 = {4'hF, 4'h0, 4'h7, 4'hD};
    localparam logic [127:0] E2 = {32'h41700000, 32'h7FC00000, 32'h34E00000, 32'h419C0000};
    localparam logic [63:0]  A3 = {16'h3C00, 16'h0001, 16'h7E00, 16'h7D00};
    localparam logic [15:0]  B3 = {4'hF, 4'h8, 4'h2, 4'h1};
    localparam logic [127:0] E3 = {32'hBF800000, 32'hB5000000, 32'h7FC00000, 32'h7FC00000};
    localparam logic [127:0] E1_MASK = {32'h0, 32'hFF800000, 32'h0, 32'hC0900000};

    // FP32 encoding of a small non-negative integer scaled by 2^sc
    function automatic logic [31:0] f32_of(input int n, input int sc);
        int p;
        if (n == 0) return 32'h0;
        p = 0;
        for (int j = 0; j < 4; j++) if (n[j]) p = j;
        return {1'b0, 8'(127 + p + sc), 23'(n << (23 - p))};
    endfunction

    function automatic logic [127:0] stream_exp(input int i);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) r[32*l +: 32] = f32_of((i * 3 + l) % 16, i % 2);
        return r;
    endfunction

    task automatic do_beat(input logic [63:0] a, input logic [15:0] b, input logic sgn, input logic [3:0] en,
                           output logic [127:0] res, output logic [7:0] flg, output int lat);
        int n;
        @(negedge clk_i);
        operand_a_i  = a;
        operand_b_i  = b;
        int_signed_i = sgn;
        lane_en_i    = en;
        out_ready_i  = 1'b1;
        in_valid_i   = 1'b1;
        n = 0;
        while (!in_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        res = result_o;
        flg = flags_o;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic [7:0]   flg;
        logic         stall;
        logic         saw;
        int           lat, tx, rx, cyc;

        rst_ni         = 1'b0;
        in_valid_i     = 1'b0;
        int_signed_i   = 1'b0;
        lane_en_i      = 4'hF;
        operand_a_i    = '0;
        operand_b_i    = '0;
        out_ready_i    = 1'b1;
        clear_status_i = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_result", result_o, 128'h0);
        chk("rst_flags", flags_o, 8'h0);
        chk("rst_status", status_o, 2'b00);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", in_ready_o, 1'b1);

        do_beat(A1, B1, 1'b1, 4'hF, res, flg, lat);
        chk("b1_latency", lat, 2);
        chk("b1_result", res, E1);
        chk("b1_flags", flg, 8'h00);
        @(negedge clk_i);
        chk("b1_status", status_o, 2'b00);

        do_beat(A2, B2, 1'b0, 4'hF, res, flg, lat);
        chk("b2_latency", lat, 2);
        chk("b2_result", res, E2);
        chk("b2_flags", flg, 8'h20);
        @(negedge clk_i);
        chk("b2_status", status_o, 2'b10);
        @(negedge clk_i);
        chk("status_sticky", status_o, 2'b10);
        clear_status_i = 1'b1;
        @(negedge clk_i);
        clear_status_i = 1'b0;
        chk("status_clear", status_o, 2'b00);

        do_beat(A3, B3, 1'b1, 4'hF, res, flg, lat);
        chk("b3_result", res, E3);
        chk("b3_flags", flg, 8'h02);
        clear_status_i = 1'b1;
        @(negedge clk_i);
        clear_status_i = 1'b0;
        chk("clear_priority", status_o, 2'b00);

        tx = 0; rx = 0; cyc = 0; stall = 1'b0; held = '0;
        int_signed_i = 1'b0;
        lane_en_i    = 4'hF;
        while (rx < 16 && cyc < 400) begin
            @(negedge clk_i);
            if (cyc < 4)       out_ready_i = 1'b0;
            else if (cyc == 4) out_ready_i = 1'b1;
            else               out_ready_i = 1'($urandom_range(0, 1));
            in_valid_i = (tx < 16);
            for (int l = 0; l < 4; l++) begin
                operand_a_i[16*l +: 16] = (tx % 2 == 1) ? 16'h4000 : 16'h3C00;
                operand_b_i[4*l +: 4]   = 4'((tx * 3 + l) % 16);
            end
            #1;
            if (stall) begin
                chk("stall_valid", out_valid_o, 1'b1);
                chk("stall_hold", result_o, held);
            end
            if (cyc == 3) chk("full_blocks_push", in_ready_o, 1'b0);
            if (cyc == 4) chk("full_push_pop", in_ready_o, 1'b1);
            if (out_valid_o && out_ready_i) begin
                chk("stream_result", result_o, stream_exp(rx));
                rx++;
            end
            stall = out_valid_o && !out_ready_i;
            held  = result_o;
            if (in_valid_i && in_ready_o) tx++;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("stream_count", rx, 16);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            saw = saw | out_valid_o;
        end
        chk("stream_no_extra", saw, 1'b0);

        @(negedge clk_i);
        operand_a_i  = A1;
        operand_b_i  = B1;
        int_signed_i = 1'b1;
        in_valid_i   = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        chk("inflight_valid", out_valid_o, 1'b1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", out_valid_o, 1'b0);
        chk("rst_async_result", result_o, 128'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            saw = saw | out_valid_o;
        end
        chk("no_stale_beat", saw, 1'b0);
        chk("ready_after_midrst", in_ready_o, 1'b1);

        do_beat(A1, B1, 1'b1, 4'b0101, res, flg, lat);
        chk("lane_en_result", res, E1_MASK);
        chk("lane_en_flags", flg, 8'h00);
        chk("lane_en_latency", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
